// File: rtl/axi4_bch_drop_arbiter.sv
// Drop-ID queue, W-drain FSM and B-channel arbiter producing SLVERR completions for rejected writes.
// Optional drop counter port enabled by defining AXI_BCH_DROP_CNT_EN.
module axi4_bch_drop_arbiter #(
    parameter int C_AXI_ID_WIDTH   = 10,
    parameter int C_AXI_USER_WIDTH = 4,
    parameter int C_DROP_DEPTH     = 4,
    parameter int C_MAX_M_BURST    = 8
) (
    input  logic                        axi4_aclk,
    input  logic                        axi4_arst,
    input  logic                        drop_valid,
    input  logic [C_AXI_ID_WIDTH-1:0]   drop_id,
    output logic                        drop_ready,
    input  logic                        s_axi4_wvalid,
    input  logic                        s_axi4_wlast,
    output logic                        w_drain_active,
    output logic                        w_drain_wready,
    input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_bid,
    input  logic [1:0]                  m_axi4_bresp,
    input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_buser,
    input  logic                        m_axi4_bvalid,
    output logic                        m_axi4_bready,
    output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_bid,
    output logic [1:0]                  s_axi4_bresp,
    output logic [C_AXI_USER_WIDTH-1:0] s_axi4_buser,
    output logic                        s_axi4_bvalid,
    input  logic                        s_axi4_bready
`ifdef AXI_BCH_DROP_CNT_EN
    ,
    output logic [15:0]                 drop_cnt
`endif
);

    localparam int AW = $clog2(C_DROP_DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = $clog2(C_MAX_M_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(C_MAX_M_BURST);

    typedef enum logic [1:0] {IDLE, DRAIN, RESP} state_e;

    state_e                    state_q, state_d;
    logic [C_AXI_ID_WIDTH-1:0] fifo_q [C_DROP_DEPTH];
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                      lock_q, lock_d, lock_grant_q;
    logic [BW-1:0]             burst_q, burst_d;
    logic                      fifo_full, fifo_empty, push;
    logic                      l_req, grant_l, l_hs, m_hs;
    logic [C_AXI_ID_WIDTH-1:0] head_id;

    // The extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign drop_ready = !fifo_full;
    assign push       = drop_valid && !fifo_full;
    assign wr_ptr_d   = wr_ptr_q + PW'(push);
    assign rd_ptr_d   = rd_ptr_q + PW'(l_hs);
    assign head_id    = fifo_q[rd_ptr_q[AW-1:0]];
    assign l_req      = (state_q == RESP);

    always_ff @(posedge axi4_aclk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= drop_id;
        end
    end

    always_comb begin
        state_d        = state_q;
        w_drain_active = 1'b0;
        w_drain_wready = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = DRAIN;
            end
            DRAIN: begin
                w_drain_active = 1'b1;
                w_drain_wready = 1'b1;
                if (s_axi4_wvalid && s_axi4_wlast) state_d = RESP;
            end
            RESP: begin
                if (l_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A stalled response keeps its grant; otherwise the master path wins unless starved-out L hits the burst limit.
    always_comb begin
        grant_l = 1'b0;
        if (lock_q) begin
            grant_l = lock_grant_q;
        end else if (l_req && (!m_axi4_bvalid || burst_q == BURST_MAX)) begin
            grant_l = 1'b1;
        end
        s_axi4_bvalid = grant_l ? l_req   : m_axi4_bvalid;
        s_axi4_bid    = grant_l ? head_id : m_axi4_bid;
        s_axi4_bresp  = grant_l ? 2'b10   : m_axi4_bresp;
        s_axi4_buser  = grant_l ? '0      : m_axi4_buser;
        m_axi4_bready = !grant_l && s_axi4_bready;
        l_hs          = grant_l && l_req && s_axi4_bready;
        m_hs          = m_axi4_bvalid && m_axi4_bready;
        lock_d        = s_axi4_bvalid && !s_axi4_bready;
        burst_d       = burst_q;
        if (!l_req || grant_l) begin
            burst_d = '0;
        end else if (m_hs && burst_q != BURST_MAX) begin
            burst_d = burst_q + BW'(1);
        end
    end

    always_ff @(posedge axi4_aclk) begin
        if (axi4_arst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_grant_q <= 1'b0;
            burst_q      <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            lock_q       <= lock_d;
            lock_grant_q <= grant_l;
            burst_q      <= burst_d;
        end
    end

`ifdef AXI_BCH_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge axi4_aclk) begin
        if (axi4_arst) begin
            drop_cnt_q <= '0;
        end else if (l_hs) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
